// File: rtl/mux4_rr_arbiter_if.sv
// Bus between four requesting sources, the arbiter and the downstream consumer.
interface mux4_rr_arbiter_if #(
    parameter int unsigned WIDTH = 28
);
    logic [3:0]       req;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic             out_ready;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    // Sources and downstream consumer side.
    modport master (
        output req, in1, in2, in3, in4, out_ready,
        input  grant, sel, out_data, out_valid
    );

    // Arbiter side.
    modport slave (
        input  req, in1, in2, in3, in4, out_ready,
        output grant, sel, out_data, out_valid
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter with a single registered output slot.

// Plain 4:1 data selector.
module mux4 #(
    parameter int unsigned WIDTH = 28
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);
    // Select one input word without modification.
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module mux4_rr_arbiter #(
    parameter int unsigned WIDTH = 28
) (
    input logic            clk,
    input logic            reset_n,
    mux4_rr_arbiter_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       win_idx;
    logic             win_found;
    logic             slot_free;
    logic [WIDTH-1:0] mux_out;

    // Rotating priority search starting at ptr; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            if (!win_found && bus.req[ptr + 2'(i)]) begin
                win_found = 1'b1;
                win_idx   = ptr + 2'(i);
            end
        end
    end

    // The slot can take a new word when empty or when the held word leaves this cycle.
    always_comb begin
        slot_free = (state == EMPTY) || bus.out_ready;
    end

    // Data path select follows this cycle's winner, not the registered sel.
    mux4 #(.WIDTH(WIDTH)) u_mux4 (
        .d0  (bus.in1),
        .d1  (bus.in2),
        .d2  (bus.in3),
        .d3  (bus.in4),
        .sel (win_idx),
        .y   (mux_out)
    );

    // Output slot state, pointer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= EMPTY;
            ptr           <= 2'd0;
            bus.out_valid <= 1'b0;
            bus.grant     <= 4'b0000;
            bus.sel       <= 2'd0;
            bus.out_data  <= '0;
        end else begin
            bus.grant <= 4'b0000;
            if (slot_free) begin
                if (win_found) begin
                    state         <= FULL;
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= mux_out;
                    bus.sel       <= win_idx;
                    bus.grant     <= 4'b0001 << win_idx;
                    ptr           <= win_idx + 2'd1;
                end else begin
                    state         <= EMPTY;
                    bus.out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 28, data width of every input and the output.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request vector; req[0..3] belong to sources in1..in4.
REQ-005 in1, in2, in3, in4  input  WIDTH each  source data, valid while the matching req bit is high.
REQ-006 out_ready  input  1  downstream accepts out_data when out_valid & out_ready.
REQ-007 grant  output  4  registered one-hot acknowledge, high for exactly one cycle per accepted source word.
REQ-008 sel  output  2  registered index of the most recent winner (00=in1 .. 11=in4).
REQ-009 out_data  output  WIDTH  registered selected word.
REQ-010 out_valid  output  1  out_data holds an unaccepted word.

Function
REQ-011 The block SHALL instantiate mux4 for data selection; its select SHALL be driven combinationally by the current-cycle winner index, not by the sel port.
REQ-012 The block SHALL keep a 2-bit round-robin pointer ptr; the search order SHALL be ptr, ptr+1, ptr+2, ptr+3 (mod 4), and the first set req bit in that order wins.
REQ-013 The block SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 A slot is free in a cycle when state is EMPTY, or state is FULL and out_ready=1.
REQ-015 When a slot is free and req!=0, on the next edge: out_data <= mux4 output, out_valid <= 1, sel <= winner, grant <= one-hot(winner), ptr <= winner+1 mod 4.
REQ-016 When a slot is free and req==0, on the next edge: out_valid <= 0, grant <= 0; out_data, sel and ptr SHALL hold.
REQ-017 In FULL with out_ready=0: out_data, sel, out_valid and ptr SHALL hold and grant SHALL be 0 (no new grant).
REQ-018 Latency: req rising in cycle N while EMPTY yields grant and out_valid in cycle N+1.
REQ-019 Accept and new win in the same cycle SHALL chain back-to-back: out_valid stays 1, new word appears next cycle; sustained throughput one word per cycle.
REQ-020 The source word SHALL be sampled at the edge that asserts its grant; a source SHALL hold req and data until it sees grant, and deasserts or presents the next word the cycle after.
REQ-021 A req bit dropped before grant SHALL be ignored without error; grant SHALL never be asserted for a source whose req was 0 in the deciding cycle.
REQ-022 ptr wrap 3 -> 0 SHALL be seamless; no source SHALL wait more than 3 grants while continuously requesting.
REQ-023 out_data SHALL be a bit-exact copy of the selected input; no width change, no arithmetic.

Reset
REQ-024 While reset_n=0, asynchronously: out_valid=0, grant=0000, sel=00, out_data=0, ptr=00, state EMPTY.
REQ-025 Reset asserted mid-operation SHALL discard any held word; after release the first grant SHALL follow REQ-012 with ptr=00.
REQ-026 No grant SHALL be issued on the first edge at which reset_n is sampled low.

Verification
REQ-027 Single source: after reset, req=0001, in1=28'h0000555, out_ready=1 -> next cycle grant=0001, sel=00, out_valid=1, out_data=28'h0000555.
REQ-028 Full contention: req=1111 held, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001 on consecutive cycles, out_valid continuously 1.
REQ-029 Backpressure: req=0100, in3=28'h0004010, out_ready=0 for 3 cycles then 1 -> single grant=0100 pulse, out_data=28'h0004010 stable for 4 cycles, out_valid drops after accept if req=0.
REQ-030 Pointer priority: after granting in2 (ptr=10), req=0011 -> grant=0001 (in1 beats in2), sel=00.
REQ-031 Reset mid-hold: out_valid=1, out_ready=0, reset_n pulsed low -> out_valid=0 immediately, then req=1111 -> first grant=0001.
REQ-032 Idle drain: one word held, req=0, out_ready=1 -> out_valid=0 next cycle, grant stays 0000, sel unchanged.
